// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns single read/write commands into AXI4-Lite
// transactions, one at a time, and returns one response per command.
// Optional watchdog: define AXIL_CMD_MASTER_TIMEOUT_EN to abort a transaction
// that the slave has not finished within TIMEOUT_CYCLES clocks.
//
// Handshake rule used on every channel (cmd, rsp and all AXI channels): a
// transfer happens on a rising edge where valid and ready are both high; once
// valid is raised, it and its payload stay unchanged until that transfer.
module axil_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  // command channel
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response channel
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  // FSM state for debug/checkers (IDLE=0 WR=1 WRESP=2 RD_ADDR=3 RD_DATA=4 RSP=5)
  output logic [2:0]                      dbg_state,
  // AXI4-Lite write address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // AXI4-Lite write data
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // AXI4-Lite write response
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // AXI4-Lite read address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // AXI4-Lite read data
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WRESP   = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t                            state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic                              aw_hs;
  logic                              w_hs;
  logic                              tmo_fire;

  // Payload comes only from registers captured at command accept, so it is
  // stable for the whole life of each VALID.
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             slave_hs;
  logic             waiting;

  // ">=" keeps the abort armed if a partial write handshake postponed it.
  assign tmo_hit = (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign waiting = (state == S_WR) || (state == S_WRESP) ||
                   (state == S_RD_ADDR) || (state == S_RD_DATA);

  // Any slave handshake this cycle wins over the watchdog.
  always_comb begin
    slave_hs = 1'b0;
    case (state)
      S_WR:      slave_hs = aw_hs | w_hs;
      S_WRESP:   slave_hs = M_AXI_BVALID;
      S_RD_ADDR: slave_hs = M_AXI_ARREADY;
      S_RD_DATA: slave_hs = M_AXI_RVALID;
      default:   slave_hs = 1'b0;
    endcase
  end

  assign tmo_fire = tmo_hit & waiting & ~slave_hs;

  // Watchdog counter: held at zero in IDLE so it starts at zero on entry to
  // WR/RD_ADDR, then counts every cycle spent waiting on the slave.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      tmo_cnt <= '0;
    end else if (state == S_IDLE) begin
      tmo_cnt <= '0;
    end else if (waiting) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Timeout flag: set with an aborted transaction, cleared when its response
  // is consumed, so normal responses always see it low.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      rsp_timeout <= 1'b0;
    end else if (tmo_fire) begin
      rsp_timeout <= 1'b1;
    end else if (state == S_RSP && rsp_ready) begin
      rsp_timeout <= 1'b0;
    end
  end
`else
  // Without the watchdog the block waits on the slave indefinitely.
  logic unused_tmo_param;
  assign unused_tmo_param = ^TIMEOUT_CYCLES;
  assign tmo_fire    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Main transaction FSM; every AXI and response output is a register here.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            if (cmd_write) begin
              state         <= S_WR;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
            end else begin
              state         <= S_RD_ADDR;
              M_AXI_ARVALID <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (aw_hs) M_AXI_AWVALID <= 1'b0;
          if (w_hs)  M_AXI_WVALID  <= 1'b0;
          // Each channel is done if it already dropped or completes now.
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
              (!M_AXI_WVALID  || M_AXI_WREADY)) begin
            state        <= S_WRESP;
            M_AXI_BREADY <= 1'b1;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= S_RSP;
          end
        end
        S_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            rsp_valid    <= 1'b1;
            state        <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Watchdog abort overrides whatever the waiting state decided.
      if (tmo_fire) begin
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= '0;
        state         <= S_RSP;
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed steps plus a randomized phase, with a
// behavioural AXI-Lite register-file slave (16 words at 0x4000_0000,
// SLVERR outside it) and a word-level reference model of expected responses.
module tb_axil_cmd_master;
  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h4000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [2:0]  dbg_state;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axil_cmd_master #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .dbg_state(dbg_state),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // ---------------- slave model ----------------
  int   cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0;
  int   cfg_ar_wait = 0, cfg_r_wait = 0;
  bit   mute = 1'b0;
  logic [31:0] s_mem [16] = '{default: 32'h0};
  int   s_aw_cnt, s_w_cnt, s_ar_cnt, s_b_cnt, s_r_cnt;
  logic s_aw_have, s_w_have, s_ar_have;
  logic [31:0] s_aw_addr, s_w_data, s_ar_addr;
  logic [3:0]  s_w_strb;
  logic aw_hs, w_hs, ar_hs;
  logic [31:0] eff_awaddr, eff_wdata, eff_araddr;
  logic [3:0]  eff_wstrb;

  assign awready = awvalid && !mute && (s_aw_cnt >= cfg_aw_wait);
  assign wready  = wvalid  && !mute && (s_w_cnt  >= cfg_w_wait);
  assign arready = arvalid && !mute && (s_ar_cnt >= cfg_ar_wait);
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign eff_awaddr = aw_hs ? awaddr : s_aw_addr;
  assign eff_wdata  = w_hs  ? wdata  : s_w_data;
  assign eff_wstrb  = w_hs  ? wstrb  : s_w_strb;
  assign eff_araddr = ar_hs ? araddr : s_ar_addr;

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd64);
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      s_aw_cnt <= 0; s_w_cnt <= 0; s_ar_cnt <= 0; s_b_cnt <= 0; s_r_cnt <= 0;
      s_aw_have <= 1'b0; s_w_have <= 1'b0; s_ar_have <= 1'b0;
      s_aw_addr <= '0; s_w_data <= '0; s_w_strb <= '0; s_ar_addr <= '0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00;
      rdata <= '0;
    end else begin
      if (aw_hs) begin
        s_aw_have <= 1'b1; s_aw_addr <= awaddr; s_aw_cnt <= 0;
      end else if (awvalid) s_aw_cnt <= s_aw_cnt + 1;
      else s_aw_cnt <= 0;
      if (w_hs) begin
        s_w_have <= 1'b1; s_w_data <= wdata; s_w_strb <= wstrb; s_w_cnt <= 0;
      end else if (wvalid) s_w_cnt <= s_w_cnt + 1;
      else s_w_cnt <= 0;
      if (bvalid && bready) begin
        bvalid <= 1'b0; s_aw_have <= 1'b0; s_w_have <= 1'b0; s_b_cnt <= 0;
      end else if ((s_aw_have || aw_hs) && (s_w_have || w_hs) && !bvalid && !mute) begin
        if (s_b_cnt >= cfg_b_wait) begin
          bvalid <= 1'b1;
          if (in_range(eff_awaddr)) begin
            for (int i = 0; i < 4; i++)
              if (eff_wstrb[i]) s_mem[eff_awaddr[5:2]][8*i +: 8] <= eff_wdata[8*i +: 8];
            bresp <= 2'b00;
          end else bresp <= 2'b10;
        end else s_b_cnt <= s_b_cnt + 1;
      end
      if (ar_hs) begin
        s_ar_have <= 1'b1; s_ar_addr <= araddr; s_ar_cnt <= 0;
      end else if (arvalid) s_ar_cnt <= s_ar_cnt + 1;
      else s_ar_cnt <= 0;
      if (rvalid && rready) begin
        rvalid <= 1'b0; s_ar_have <= 1'b0; s_r_cnt <= 0;
      end else if ((s_ar_have || ar_hs) && !rvalid && !mute) begin
        if (s_r_cnt >= cfg_r_wait) begin
          rvalid <= 1'b1;
          if (in_range(eff_araddr)) begin
            rdata <= s_mem[eff_araddr[5:2]]; rresp <= 2'b00;
          end else begin
            rdata <= 32'h0; rresp <= 2'b10;
          end
        end else s_r_cnt <= s_r_cnt + 1;
      end
    end
  end

  // ---------------- protocol monitors ----------------
  int cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cnt = 0, rsp_hs_cnt = 0;
  int stab_err = 0;
  logic p_aw, p_w, p_ar;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aw_hs) aw_hs_cyc <= cyc;
    if (w_hs)  w_hs_cyc  <= cyc;
    if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
    if (rsp_valid && rsp_ready) rsp_hs_cnt <= rsp_hs_cnt + 1;
    if (!rstn) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
    end else begin
      if (p_aw && (!awvalid || awaddr !== p_awaddr)) stab_err <= stab_err + 1;
      if (p_w && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) stab_err <= stab_err + 1;
      if (p_ar && (!arvalid || araddr !== p_araddr)) stab_err <= stab_err + 1;
      if ((awprot | arprot) !== 3'b000) stab_err <= stab_err + 1;
      p_aw <= awvalid && !awready; p_awaddr <= awaddr;
      p_w  <= wvalid && !wready;   p_wdata <= wdata; p_wstrb <= wstrb;
      p_ar <= arvalid && !arready; p_araddr <= araddr;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0, errors = 0;
  logic [34:0] exp_q[$];
  logic [31:0] ref_mem [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {timeout, resp, rdata} from the register-file rules.
  function automatic logic [34:0] model_rsp(input bit wr, input logic [31:0] a,
                                            input logic [31:0] d, input logic [3:0] s);
    int idx;
    logic [31:0] w;
    if (!in_range(a)) return {1'b0, 2'b10, 32'h0};
    idx = int'((a - BASE) / 4);
    if (wr) begin
      w = ref_mem[idx];
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[idx] = w;
      return {1'b0, 2'b00, 32'h0};
    end
    return {1'b0, 2'b00, ref_mem[idx]};
  endfunction

  // ---------------- driver ----------------
  task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold,
                        output logic [34:0] obs, output int lat,
                        output bit stable, output logic [4:0] axi_o);
    int n;
    stable = 1'b1;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accept_wait", 64'(n < 50), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    check("rsp_wait", 64'(n < 200), 64'd1);
    lat   = n + 1;
    obs   = {rsp_timeout, rsp_resp, rsp_rdata};
    axi_o = {awvalid, wvalid, arvalid, bready, rready};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || {rsp_timeout, rsp_resp, rsp_rdata} !== obs) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [34:0] obs;
    logic [4:0]  axi_o;
    logic [31:0] a, d;
    logic [3:0]  s;
    int lat, b0, r0, n;
    bit stable, wr, saw_rsp;

    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_timeout, busy}, 0);
    check("rst_rsp_data", {rsp_resp, rsp_rdata}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // write to register 1, zero-wait slave
    exp_q.push_back(model_rsp(1'b1, 32'h4000_0004, 32'hAA00_0001, 4'hF));
    do_cmd(1'b1, 32'h4000_0004, 32'hAA00_0001, 4'hF, 0, obs, lat, stable, axi_o);
    check("wr1_rsp", obs, exp_q.pop_front());
    check("wr1_latency", lat, 3);
    check("wr1_axi_idle_in_rsp", axi_o, 0);
    check("wr1_slave_reg1", s_mem[1], 32'hAA00_0001);

    // read it back, response held 5 cycles
    exp_q.push_back(model_rsp(1'b0, 32'h4000_0004, 32'h0, 4'h0));
    do_cmd(1'b0, 32'h4000_0004, 32'h0, 4'h0, 5, obs, lat, stable, axi_o);
    check("rd1_rsp", obs, exp_q.pop_front());
    check("rd1_latency", lat, 3);
    check("rd1_hold_stable", stable, 1);
    check("rd1_cmd_ready_after", cmd_ready, 1);

    // WREADY three cycles ahead of AWREADY
    cfg_aw_wait = 3; cfg_w_wait = 0;
    b0 = b_hs_cnt; r0 = rsp_hs_cnt;
    exp_q.push_back(model_rsp(1'b1, 32'h4000_0008, 32'h1234_5678, 4'b0101));
    do_cmd(1'b1, 32'h4000_0008, 32'h1234_5678, 4'b0101, 1, obs, lat, stable, axi_o);
    check("split_rsp", obs, exp_q.pop_front());
    check("split_aw_after_w", aw_hs_cyc - w_hs_cyc, 3);
    check("split_b_count", b_hs_cnt - b0, 1);
    check("split_rsp_count", rsp_hs_cnt - r0, 1);
    cfg_aw_wait = 0;

    // slave error responses pass through
    exp_q.push_back(model_rsp(1'b0, 32'h5000_0000, 32'h0, 4'h0));
    do_cmd(1'b0, 32'h5000_0000, 32'h0, 4'h0, 0, obs, lat, stable, axi_o);
    check("rd_slverr", obs, exp_q.pop_front());
    exp_q.push_back(model_rsp(1'b1, 32'h4000_0080, 32'hDEAD_BEEF, 4'hF));
    do_cmd(1'b1, 32'h4000_0080, 32'hDEAD_BEEF, 4'hF, 0, obs, lat, stable, axi_o);
    check("wr_slverr", obs, exp_q.pop_front());

    // randomized traffic with random slave wait states
    for (int t = 0; t < 30; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = BASE + {26'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 7) == 0) a = a + 32'd64;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      cfg_aw_wait = $urandom_range(0, 3); cfg_w_wait = $urandom_range(0, 3);
      cfg_b_wait  = $urandom_range(0, 3); cfg_ar_wait = $urandom_range(0, 3);
      cfg_r_wait  = $urandom_range(0, 3);
      exp_q.push_back(model_rsp(wr, a, d, s));
      do_cmd(wr, a, d, s, $urandom_range(0, 2), obs, lat, stable, axi_o);
      check($sformatf("rand%0d_rsp", t), obs, exp_q.pop_front());
      check($sformatf("rand%0d_axi_idle", t), axi_o, 0);
      check($sformatf("rand%0d_stable", t), stable, 1);
    end
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0; cfg_ar_wait = 0; cfg_r_wait = 0;

    // reset while waiting for read data
    cfg_r_wait = 40;
    cmd_write = 1'b0; cmd_addr = 32'h4000_0004; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    check("rst_mid_reach_rd_data", 64'(n < 20), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {busy, rready, rsp_valid, arvalid}, 0);
    rstn = 1'b1;
    cfg_r_wait = 0;
    check("rst_mid_cmd_ready", cmd_ready, 1);
    saw_rsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("rst_mid_no_rsp", saw_rsp, 0);
    exp_q.push_back(model_rsp(1'b0, 32'h4000_0004, 32'h0, 4'h0));
    do_cmd(1'b0, 32'h4000_0004, 32'h0, 4'h0, 0, obs, lat, stable, axi_o);
    check("rst_mid_next_read", obs, exp_q.pop_front());

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // unresponsive slave: watchdog abort
    mute = 1'b1;
    exp_q.push_back({1'b1, 2'b10, 32'h0});
    do_cmd(1'b0, 32'h4000_0010, 32'h0, 4'h0, 1, obs, lat, stable, axi_o);
    check("tmo_rsp", obs, exp_q.pop_front());
    check("tmo_latency", lat, TMO + 1);
    check("tmo_axi_idle", axi_o, 0);
    check("tmo_cmd_ready_after", cmd_ready, 1);
    mute = 1'b0;
    exp_q.push_back(model_rsp(1'b0, 32'h4000_0008, 32'h0, 4'h0));
    do_cmd(1'b0, 32'h4000_0008, 32'h0, 4'h0, 0, obs, lat, stable, axi_o);
    check("tmo_next_read", obs, exp_q.pop_front());
`endif

    check("payload_stability", stab_err, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=stuck expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32, AXI-Lite data width; the only supported value is 32.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit in clocks; used only when AXIL_CMD_MASTER_TIMEOUT_EN is defined.
REQ-004 The block SHALL have one clock, M_AXI_ACLK; reset M_AXI_ARESETN is synchronous and active-low.
REQ-005 M_AXI_ACLK  in  1  clock; all logic is rising-edge.
REQ-006 M_AXI_ARESETN  in  1  synchronous active-low reset.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr / cmd_wdata / cmd_wstrb  in  ADDR / 32 / 4  command address, write data and byte strobes.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_rdata / rsp_resp / rsp_timeout  out  32 / 2 / 1  read data, AXI response code and timeout flag.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 M_AXI_AW*, W*, B*, AR*, R*  AXI4-Lite master ports with standard directions and widths (ADDR, PROT[2:0], WDATA 32, WSTRB 4, RESP[1:0]).

Function
REQ-014 The FSM SHALL have the states IDLE, WR, WRESP, RD_ADDR, RD_DATA and RSP, and SHALL allow at most one transaction outstanding.
REQ-015 cmd_ready SHALL equal (state==IDLE); in IDLE, cmd_valid routes to WR when cmd_write=1 and to RD_ADDR when cmd_write=0, and the block registers addr, wdata and wstrb on that edge.
REQ-016 AWVALID and WVALID (or ARVALID) SHALL assert on the first edge after command acceptance, driven from registers with no combinational path from cmd_*.
REQ-017 In WR, AWVALID and WVALID SHALL each drop independently on their own handshake; WR SHALL exit to WRESP once both handshakes have occurred, including when both occur in the same cycle.
REQ-018 AWADDR, WDATA and WSTRB SHALL remain stable while the matching VALID is high.
REQ-019 BREADY SHALL be high only in WRESP; on BVALID the block captures BRESP, sets rsp_rdata=0 and goes to RSP.
REQ-020 ARVALID SHALL drop on ARREADY and the FSM SHALL go to RD_DATA, where RREADY is high; on RVALID the block captures RDATA and RRESP and goes to RSP.
REQ-021 In RSP, rsp_valid=1 and all rsp_* outputs SHALL be held stable until rsp_ready; the FSM SHALL then return to IDLE, and a next command is accepted no earlier than the following cycle.
REQ-022 AWPROT and ARPROT SHALL be tied to 3'b000.
REQ-023 A non-OKAY BRESP or RRESP SHALL be passed through unchanged, with rsp_timeout=0.
REQ-024 Minimum latency SHALL be: command accept to rsp_valid = 3 clocks when the slave responds with zero wait states.

Reset
REQ-025 While M_AXI_ARESETN=0 at a clock edge, the block SHALL set state=IDLE and drive all AXI VALID/READY outputs, rsp_valid, rsp_timeout and busy to 0, and rsp_rdata, rsp_resp and the address/data registers to 0.
REQ-026 Reset during any non-IDLE state SHALL abandon the transaction without producing a response; cmd_ready SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-027 With AXIL_CMD_MASTER_TIMEOUT_EN defined, a counter SHALL clear on entry to WR or RD_ADDR and increment each cycle in WR, WRESP, RD_ADDR and RD_DATA.
REQ-028 With AXIL_CMD_MASTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 the block SHALL drop all AXI VALID/READY outputs, set rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0, and go to RSP.
REQ-029 A slave handshake completing in that same cycle SHALL take priority over the timeout.
REQ-030 Without AXIL_CMD_MASTER_TIMEOUT_EN, the block SHALL contain no counter, rsp_timeout SHALL be tied to 0, and the block SHALL wait indefinitely.

Verification
REQ-031 Write addr 0x40000004, data 0xAA000001, strb 0xF to an axi_regfile_v1_0_S00_AXI slave -> register 1 = 0xAA000001, rsp_resp=00, rsp_rdata=0.
REQ-032 Read of the same address -> rsp_rdata=0xAA000001, rsp_resp=00, rsp_valid held high for 5 cycles while rsp_ready=0.
REQ-033 Slave asserts WREADY 3 cycles before AWREADY -> WVALID drops first, exactly one B handshake, one response.
REQ-034 Slave returns RRESP=2'b10 -> rsp_resp=10, rsp_timeout=0.
REQ-035 With the macro defined and TIMEOUT_CYCLES=16, an unresponsive slave -> rsp_valid with rsp_resp=10 and rsp_timeout=1, ARVALID low, cmd_ready 1 after rsp_ready.
REQ-036 Reset asserted in RD_DATA -> next cycle busy=0 and RREADY=0, no rsp_valid, and a new read afterwards completes normally.
